spi_rd_word_feeder: RTL and testbench

Upstream feeder for the SPI read-slave stage. Buffers data words from the MAC/capture side in a small synchronous FIFO and presents the head word on `dout` (wired to the slave's `inport`). Drives `wtreq` so that `dout` is never sampled while changing. Uses the slave's `clr` (address-matched/transfer-active flag) to decide when a word has been consumed and must be popped.

---
 rtl/spi_feed_pkg.sv | 20 ++
 rtl/spi_feed_fifo_mem.sv | 26 ++
 rtl/spi_rd_word_feeder.sv | 153 +++++++++++++++
 tb/tb_spi_rd_word_feeder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_feed_pkg.sv
// Shared types and helpers for the SPI read-slave word feeder.
package spi_feed_pkg;

  typedef enum logic [2:0] {
    ST_EMPTY  = 3'd0,
    ST_LOAD   = 3'd1,
    ST_READY  = 3'd2,
    ST_XFER   = 3'd3,
    ST_XFER_E = 3'd4,
    ST_POP    = 3'd5
  } state_e;

  // Fill bit of the marker word presented when nothing is buffered.
  localparam logic DEF_EMPTY_FILL = 1'b1;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/spi_feed_fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port.
module spi_feed_fifo_mem
  import spi_feed_pkg::*;
#(
  parameter int unsigned Nbit  = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [ptr_width(DEPTH)-1:0]   waddr_i,
  input  logic [Nbit-1:0]               wdata_i,
  input  logic [ptr_width(DEPTH)-1:0]   raddr_i,
  output logic [Nbit-1:0]               rdata_o
);

  logic [Nbit-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spi_rd_word_feeder.sv
// Buffers capture-side words and presents the head word to the SPI read slave,
// holding wtreq while dout is being updated and popping on each transfer end.
module spi_rd_word_feeder
  import spi_feed_pkg::*;
#(
  parameter int unsigned     Nbit       = 8,
  parameter int unsigned     DEPTH      = 8,
  parameter logic [Nbit-1:0] EMPTY_CODE = {Nbit{DEF_EMPTY_FILL}}
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [Nbit-1:0]             wr_data,
  input  logic                        wr_en,
  output logic                        full,
  output logic                        empty,
  output logic [ptr_width(DEPTH):0]   level,
  output logic                        ovf,
  input  logic                        ovf_clr,
  output logic [Nbit-1:0]             dout,
  output logic                        wtreq,
  input  logic                        clr
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned LW = PW + 1;

  state_e          state_q, state_d;
  logic            clr_dly_q;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            ovf_q, ovf_d;
  logic [Nbit-1:0] dout_q, dout_d;
  logic            wtreq_q, wtreq_d;
  logic [Nbit-1:0] rd_data;
  logic            wr_acc, pop, clr_rise, clr_fall;

  assign wr_acc   = wr_en & ~full_q;
  assign pop      = (state_q == ST_POP);
  assign clr_rise = clr & ~clr_dly_q;
  assign clr_fall = ~clr & clr_dly_q;

  spi_feed_fifo_mem #(
    .Nbit  (Nbit),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Pointer, occupancy and overflow bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({wr_acc, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
    ovf_d   = (wr_en & full_q) | (ovf_q & ~ovf_clr);
  end

  // Next state; decisions use post-update occupancy so a fresh word loads at once.
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (clr_rise) begin
          state_d = ST_XFER_E;
        end else if ((level_d != '0) && !clr) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        dout_d  = rd_data;
        state_d = clr_rise ? ST_XFER : ST_READY;
      end
      ST_READY: begin
        if (clr_rise) begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (clr_fall) begin
          state_d = ST_POP;
        end
      end
      ST_XFER_E: begin
        if (clr_fall) begin
          state_d = ST_EMPTY;
        end
      end
      ST_POP: begin
        state_d = (level_d != '0) ? ST_LOAD : ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
    if ((state_d == ST_EMPTY) || (state_d == ST_XFER_E)) begin
      dout_d = EMPTY_CODE;
    end
    wtreq_d = (state_d == ST_LOAD) || (state_d == ST_POP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_EMPTY;
      clr_dly_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      dout_q    <= EMPTY_CODE;
      wtreq_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_dly_q <= clr;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      dout_q    <= dout_d;
      wtreq_q   <= wtreq_d;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;
  assign ovf   = ovf_q;
  assign dout  = dout_q;
  assign wtreq = wtreq_q;

endmodule

// File: tb/tb_spi_rd_word_feeder.sv
// Bench for spi_rd_word_feeder: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_spi_rd_word_feeder;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full, empty, ovf, ovf_clr, wtreq, clr;
  logic [3:0] level;
  logic [7:0] dout;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  spi_rd_word_feeder #(
    .Nbit       (8),
    .DEPTH      (DEPTH),
    .EMPTY_CODE (8'hFF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
    .dout    (dout),
    .wtreq   (wtreq),
    .clr     (clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stored words, the word on dout, and the transfer phase.
  // m_busy counts remaining wtreq cycles: 2 = word being popped, 1 = next word loading.
  // m_xfer: 0 none, 1 transfer of a buffered word, 2 transfer of the empty marker.
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  bit         m_ovf, m_prev_clr, m_shown;
  int         m_busy, m_xfer;

  always @(posedge clk) begin
    bit rise, fall, was_full, wacc;
    int n_after;
    if (!rst) begin
      mq.delete();
      m_dout = 8'hFF; m_ovf = 1'b0; m_prev_clr = 1'b0;
      m_shown = 1'b0; m_busy = 0; m_xfer = 0;
    end else begin
      rise     = clr && !m_prev_clr;
      fall     = !clr && m_prev_clr;
      was_full = (mq.size() == DEPTH);
      wacc     = wr_en && !was_full;
      if (m_busy == 2) begin
        void'(mq.pop_front());
        n_after = mq.size() + int'(wacc);
        if (n_after > 0) m_busy = 1;
        else begin m_busy = 0; m_shown = 1'b0; m_dout = 8'hFF; end
      end else if (m_busy == 1) begin
        m_busy  = 0;
        m_shown = 1'b1;
        m_dout  = mq[0];
        m_xfer  = rise ? 1 : 0;
      end else if (m_xfer == 1) begin
        if (fall) begin m_xfer = 0; m_busy = 2; end
      end else if (m_xfer == 2) begin
        if (fall) m_xfer = 0;
      end else if (m_shown) begin
        if (rise) m_xfer = 1;
      end else begin
        if (rise) m_xfer = 2;
        else if ((mq.size() + int'(wacc) > 0) && !clr) m_busy = 1;
      end
      if (wacc) mq.push_back(wr_data);
      if (wr_en && was_full) m_ovf = 1'b1;
      else if (ovf_clr)      m_ovf = 1'b0;
      m_prev_clr = clr;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("dout",  32'(dout),  32'(m_dout));
      check("wtreq", 32'(wtreq), 32'(m_busy != 0));
      check("level", 32'(level), 32'(mq.size()));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("full",  32'(full),  32'(mq.size() == DEPTH));
      check("ovf",   32'(ovf),   32'(m_ovf));
    end
  end

  task automatic wr(input logic [7:0] d);
    wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi);
    clr = 1'b1;
    idle(hi);
    clr = 1'b0;
    idle(4);
  endtask

  int wt_cnt;
  int clr_cnt;

  initial begin
    rst = 1'b0; wr_data = '0; wr_en = 1'b0; ovf_clr = 1'b0; clr = 1'b0;
    idle(3);
    chk_en = 1'b1;
    rst = 1'b1;
    idle(1);
    check("rst_dout",  32'(dout),  32'h0000_00FF);
    check("rst_wtreq", 32'(wtreq), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_full",  32'(full),  32'h0);
    check("rst_ovf",   32'(ovf),   32'h0);

    // Read of an empty buffer returns the marker and never stalls.
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("empty_rd_dout",  32'(dout),  32'h0000_00FF);
      check("empty_rd_wtreq", 32'(wtreq), 32'h0);
    end
    clr = 1'b0;
    idle(3);
    check("empty_rd_level", 32'(level), 32'h0);

    // Two words, two transfers.
    wr(8'hA5); wr(8'h3C);
    idle(4);
    check("a5_ready", 32'(dout),  32'h0000_00A5);
    check("lvl2",     32'(level), 32'h2);
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("a5_xfer", 32'(dout), 32'h0000_00A5);
    end
    clr = 1'b0;
    wt_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (wtreq) wt_cnt++;
    end
    check("pop_wtreq_cycles", 32'(wt_cnt), 32'h2);
    check("3c_ready",         32'(dout),   32'h0000_003C);
    pulse(3);
    check("drained_dout",  32'(dout),  32'h0000_00FF);
    check("drained_level", 32'(level), 32'h0);

    // Fill, overflow, clear overflow, drain.
    for (int i = 0; i < DEPTH; i++) wr(8'(8'h10 + i));
    idle(2);
    check("fill_full", 32'(full), 32'h1);
    wr(8'h77);
    check("ovf_set",   32'(ovf),   32'h1);
    check("ovf_level", 32'(level), 32'h8);
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      check("fill_order", 32'(dout), 32'(8'h10 + i));
      pulse(2);
    end
    check("fill_drained", 32'(level), 32'h0);

    // Write in the POP cycle leaves the level unchanged.
    wr(8'h21); wr(8'h22); wr(8'h23);
    idle(4);
    clr = 1'b1; idle(2); clr = 1'b0;
    idle(1);
    wr(8'h24);
    check("pop_wr_level", 32'(level), 32'h3);
    idle(3);
    for (int i = 0; i < 3; i++) begin
      check("pop_wr_order", 32'(dout), 32'(8'h22 + i));
      pulse(1 + i);
    end
    check("pop_wr_drained", 32'(level), 32'h0);

    // clr rise in the same cycle as the first write.
    wr_data = 8'h5A; wr_en = 1'b1; clr = 1'b1;
    idle(1);
    wr_en = 1'b0;
    check("xfer_e_dout",  32'(dout),  32'h0000_00FF);
    check("xfer_e_wtreq", 32'(wtreq), 32'h0);
    check("xfer_e_level", 32'(level), 32'h1);
    idle(2);
    clr = 1'b0;
    idle(3);
    check("xfer_e_after", 32'(dout),  32'h0000_005A);
    check("xfer_e_wt0",   32'(wtreq), 32'h0);
    pulse(2);

    // Reset mid-transfer discards the buffer; the later fall does not pop.
    for (int i = 0; i < 4; i++) wr(8'(8'h40 + i));
    idle(4);
    clr = 1'b1; idle(2);
    rst = 1'b0; idle(1); rst = 1'b1;
    check("rst_xfer_level", 32'(level), 32'h0);
    check("rst_xfer_dout",  32'(dout),  32'h0000_00FF);
    check("rst_xfer_wtreq", 32'(wtreq), 32'h0);
    idle(1);
    clr = 1'b0;
    wt_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (wtreq) wt_cnt++;
    end
    check("rst_no_pop_wt",  32'(wt_cnt), 32'h0);
    check("rst_no_pop_lvl", 32'(level),  32'h0);

    // Randomized traffic against the model.
    clr_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      wr_en   = ($urandom_range(0, 99) < ((c < 2000) ? 12 : 45));
      wr_data = 8'($urandom);
      ovf_clr = ($urandom_range(0, 99) < 4);
      if (clr_cnt == 0) begin
        clr     = ~clr;
        clr_cnt = clr ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 12));
      end else begin
        clr_cnt--;
      end
      idle(1);
    end
    wr_en = 1'b0; ovf_clr = 1'b0; clr = 1'b0;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
